// File: rtl/fibo_row_gen.sv
// fibo_row_gen
//   Builds a table of the Fibonacci numbers (modulo 2^16) after reset. Once
//   the table is built it serves one display request at a time. Each request
//   produces a 16-character ASCII line "Fibo #DD is HHHH".
//
// Ports
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   init_done  table fully built (sticky until reset)
//   req_valid  request strobe
//   req_idx    0-based table index requested
//   req_ready  block accepts a request this cycle (IDLE only)
//   row_valid  row_text holds a complete line (DONE only)
//   row_ready  consumer takes row_text this cycle
//   row_text   16 ASCII characters, [127:120] is the leftmost character
module fibo_row_gen #(
    parameter int N_ENTRIES = 25
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic         init_done,
    input  logic         req_valid,
    input  logic [4:0]   req_idx,
    output logic         req_ready,
    output logic         row_valid,
    input  logic         row_ready,
    output logic [127:0] row_text
);

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_FORMAT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [5:0]   N_K    = 6'(N_ENTRIES);
    localparam logic [47:0]  PREFIX = "Fibo #";
    localparam logic [31:0]  MIDDLE = " is ";
    localparam logic [127:0] BLANK  = {16{8'h20}};

    logic [1:0]  state;
    logic [15:0] tbl [N_ENTRIES];

    // Running pair entry(k-2), entry(k-1) so INIT never reads the table.
    logic [5:0]  init_k;
    logic [15:0] fib_a;
    logic [15:0] fib_b;
    logic [15:0] fib_sum;

    logic [4:0]  idx_q;
    logic        oor_q;
    logic [15:0] val_q;
    logic [31:0] hex_q;
    logic [2:0]  nib_cnt;

    logic        in_range;
    logic [3:0]  nib;
    logic [7:0]  nib_ascii;
    logic [5:0]  num;
    logic [7:0]  dec_tens;
    logic [7:0]  dec_ones;
    logic [127:0] line;

    assign fib_sum  = fib_a + fib_b;
    assign in_range = ({1'b0, req_idx} < N_K);

    // val_q is shifted left once per FORMAT cycle, so the top nibble is
    // always the next one to convert.
    assign nib       = val_q[15:12];
    assign nib_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

    // Displayed number is idx+1, which lies in 1..32.
    always_comb begin
        num      = {1'b0, idx_q} + 6'd1;
        dec_tens = 8'h30;
        dec_ones = 8'h30 + {2'b00, num};
        if (num >= 6'd30) begin
            dec_tens = 8'h33;
            dec_ones = 8'h30 + {2'b00, num - 6'd30};
        end else if (num >= 6'd20) begin
            dec_tens = 8'h32;
            dec_ones = 8'h30 + {2'b00, num - 6'd20};
        end else if (num >= 6'd10) begin
            dec_tens = 8'h31;
            dec_ones = 8'h30 + {2'b00, num - 6'd10};
        end
    end

    always_comb begin
        if (oor_q) begin
            line = {PREFIX, 16'h3F3F, MIDDLE, 32'h2D2D2D2D};
        end else begin
            line = {PREFIX, dec_tens, dec_ones, MIDDLE, hex_q};
        end
    end

    assign req_ready = (state == S_IDLE);
    assign row_valid = (state == S_DONE);

    // Table storage; no reset needed because INIT rewrites every slot.
    always_ff @(posedge clk) begin
        if (reset_n && state == S_INIT) begin
            if (init_k == 6'd0) begin
                tbl[0] <= 16'd0;
                tbl[1] <= 16'd1;
            end else if (init_k < N_K) begin
                tbl[init_k[4:0]] <= fib_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_INIT;
            init_done <= 1'b0;
            row_text  <= BLANK;
            init_k    <= 6'd0;
            fib_a     <= 16'd0;
            fib_b     <= 16'd0;
            idx_q     <= 5'd0;
            oor_q     <= 1'b0;
            val_q     <= 16'd0;
            hex_q     <= 32'd0;
            nib_cnt   <= 3'd0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_k == 6'd0) begin
                        fib_a  <= 16'd0;
                        fib_b  <= 16'd1;
                        init_k <= 6'd2;
                    end else if (init_k < N_K) begin
                        fib_a  <= fib_b;
                        fib_b  <= fib_sum;
                        init_k <= init_k + 6'd1;
                    end else begin
                        // Last entry was written on the previous edge.
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_idx;
                        oor_q   <= !in_range;
                        val_q   <= in_range ? tbl[req_idx] : 16'd0;
                        nib_cnt <= 3'd0;
                        state   <= S_FORMAT;
                    end
                end
                S_FORMAT: begin
                    // Four conversion cycles, then one to publish the line.
                    if (nib_cnt != 3'd4) begin
                        hex_q   <= {hex_q[23:0], nib_ascii};
                        val_q   <= {val_q[11:0], 4'h0};
                        nib_cnt <= nib_cnt + 3'd1;
                    end else begin
                        row_text <= line;
                        state    <= S_DONE;
                    end
                end
                default: begin
                    if (row_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
